// File: rtl/mux_16x1.sv
// 16-to-1 bit multiplexer built as a tree of 2:1 cells, with a registered capture stage.
// Define MUX_16X1_ONEHOT_EN to add the registered one-hot select output sel_oh.

module Mux2Cell (
  input  logic a_i,
  input  logic b_i,
  input  logic s_i,
  output logic y_o
);
  assign y_o = (a_i & ~s_i) | (b_i & s_i);
endmodule

module mux_16x1 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out,
  output logic        out_q,
`ifdef MUX_16X1_ONEHOT_EN
  output logic [3:0]  sel_q,
  output logic [15:0] sel_oh
`else
  output logic [3:0]  sel_q
`endif
);

  logic [7:0] lvl0;
  logic [3:0] lvl1;
  logic [1:0] lvl2;
  logic       lvl3;

  // Each level halves the candidates, steered by the next select bit (LSB first).
  for (genvar g = 0; g < 8; g++) begin : gLvl0
    Mux2Cell uCell (.a_i(in[2*g]), .b_i(in[2*g+1]), .s_i(sel[0]), .y_o(lvl0[g]));
  end

  for (genvar g = 0; g < 4; g++) begin : gLvl1
    Mux2Cell uCell (.a_i(lvl0[2*g]), .b_i(lvl0[2*g+1]), .s_i(sel[1]), .y_o(lvl1[g]));
  end

  for (genvar g = 0; g < 2; g++) begin : gLvl2
    Mux2Cell uCell (.a_i(lvl1[2*g]), .b_i(lvl1[2*g+1]), .s_i(sel[2]), .y_o(lvl2[g]));
  end

  Mux2Cell uLvl3 (.a_i(lvl2[0]), .b_i(lvl2[1]), .s_i(sel[3]), .y_o(lvl3));

  assign out = lvl3;

  logic       outBit_q, outBit_d;
  logic [3:0] selIdx_q, selIdx_d;

  // The tree output already equals in[sel], so it feeds the capture register directly.
  always_comb begin
    outBit_d = outBit_q;
    selIdx_d = selIdx_q;
    if (en) begin
      outBit_d = lvl3;
      selIdx_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outBit_q <= 1'b0;
      selIdx_q <= 4'd0;
    end else begin
      outBit_q <= outBit_d;
      selIdx_q <= selIdx_d;
    end
  end

  assign out_q = outBit_q;
  assign sel_q = selIdx_q;

`ifdef MUX_16X1_ONEHOT_EN
  logic [15:0] selOneHot_q, selOneHot_d;

  always_comb begin
    selOneHot_d = selOneHot_q;
    if (en) begin
      selOneHot_d = 16'h0001 << sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      selOneHot_q <= 16'h0000;
    end else begin
      selOneHot_q <= selOneHot_d;
    end
  end

  assign sel_oh = selOneHot_q;
`else
  // Without the one-hot option only out_q and sel_q are registered.
`endif

endmodule

// File: tb/tb_mux_16x1.sv
// Directed self-checking bench for mux_16x1: combinational sweeps, then the capture stage.
// Build with MUX_16X1_ONEHOT_EN defined to also check sel_oh.

module tb_mux_16x1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] in = 16'h0000;
  logic [3:0]  sel = 4'd0;
  logic        out;
  logic        out_q;
  logic [3:0]  sel_q;
`ifdef MUX_16X1_ONEHOT_EN
  logic [15:0] sel_oh;
`endif

  int assertCount = 0;
  int failCount   = 0;

  mux_16x1 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in    (in),
    .sel   (sel),
    .out   (out),
    .out_q (out_q),
`ifdef MUX_16X1_ONEHOT_EN
    .sel_q (sel_q),
    .sel_oh(sel_oh)
`else
    .sel_q (sel_q)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] inVal, input logic [3:0] selVal);
    in  = inVal;
    sel = selVal;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] combinational sweeps, rst/en undriven");
    for (int s = 0; s < 16; s++) begin
      applyStimulus(16'h5555, 4'(s));
      checkOutput($sformatf("sweep5555_sel%0d", s), {15'd0, out}, {15'd0, (s % 2 == 0)});
    end
    for (int s = 0; s < 16; s++) begin
      applyStimulus(16'hAAAA, 4'(s));
      checkOutput($sformatf("sweepAAAA_sel%0d", s), {15'd0, out}, {15'd0, (s % 2 == 1)});
    end
    for (int s = 0; s < 16; s++) begin
      applyStimulus(16'h0001, 4'(s));
      checkOutput($sformatf("sweep0001_sel%0d", s), {15'd0, out}, {15'd0, (s == 0)});
    end
    for (int s = 0; s < 16; s++) begin
      applyStimulus(16'h8000, 4'(s));
      checkOutput($sformatf("sweep8000_sel%0d", s), {15'd0, out}, {15'd0, (s == 15)});
    end

    // 16'hC3A5 = 1100_0011_1010_0101
    applyStimulus(16'hC3A5, 4'd5);
    checkOutput("mixed_sel5", {15'd0, out}, 16'd1);
    applyStimulus(16'hC3A5, 4'd8);
    checkOutput("mixed_sel8", {15'd0, out}, 16'd1);
    applyStimulus(16'hC3A5, 4'd10);
    checkOutput("mixed_sel10", {15'd0, out}, 16'd0);
    applyStimulus(16'hC3A5, 4'd14);
    checkOutput("mixed_sel14", {15'd0, out}, 16'd1);
    applyStimulus(16'hC3A5, 4'd6);
    checkOutput("mixed_sel6", {15'd0, out}, 16'd0);

    $display("[TB] registered path");
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    stepClock();
    stepClock();
    checkOutput("reset_out_q", {15'd0, out_q}, 16'd0);
    checkOutput("reset_sel_q", {12'd0, sel_q}, 16'd0);
`ifdef MUX_16X1_ONEHOT_EN
    checkOutput("reset_sel_oh", sel_oh, 16'h0000);
`endif

    rst = 1'b0;
    en  = 1'b1;
    applyStimulus(16'h8000, 4'd15);
    stepClock();
    checkOutput("cap15_out_q", {15'd0, out_q}, 16'd1);
    checkOutput("cap15_sel_q", {12'd0, sel_q}, 16'd15);
`ifdef MUX_16X1_ONEHOT_EN
    checkOutput("cap15_sel_oh", sel_oh, 16'h8000);
`endif

    en = 1'b0;
    applyStimulus(16'h8000, 4'd0);
    checkOutput("hold_out_comb", {15'd0, out}, 16'd0);
    stepClock();
    checkOutput("hold_out_q", {15'd0, out_q}, 16'd1);
    checkOutput("hold_sel_q", {12'd0, sel_q}, 16'd15);
`ifdef MUX_16X1_ONEHOT_EN
    checkOutput("hold_sel_oh", sel_oh, 16'h8000);
`endif
    applyStimulus(16'h0000, 4'd3);
    stepClock();
    checkOutput("hold2_out_q", {15'd0, out_q}, 16'd1);
    checkOutput("hold2_sel_q", {12'd0, sel_q}, 16'd15);

    en = 1'b1;
    applyStimulus(16'h0020, 4'd5);
    stepClock();
    checkOutput("cap5_out_q", {15'd0, out_q}, 16'd1);
    checkOutput("cap5_sel_q", {12'd0, sel_q}, 16'd5);
`ifdef MUX_16X1_ONEHOT_EN
    checkOutput("cap5_sel_oh", sel_oh, 16'h0020);
`endif

    applyStimulus(16'h0020, 4'd4);
    stepClock();
    checkOutput("cap4_out_q", {15'd0, out_q}, 16'd0);
    checkOutput("cap4_sel_q", {12'd0, sel_q}, 16'd4);
`ifdef MUX_16X1_ONEHOT_EN
    checkOutput("cap4_sel_oh", sel_oh, 16'h0010);
`endif

    rst = 1'b1;
    en  = 1'b1;
    applyStimulus(16'hFFFF, 4'd9);
    checkOutput("rstpri_out_comb_pre", {15'd0, out}, 16'd1);
    stepClock();
    checkOutput("rstpri_out_q", {15'd0, out_q}, 16'd0);
    checkOutput("rstpri_sel_q", {12'd0, sel_q}, 16'd0);
`ifdef MUX_16X1_ONEHOT_EN
    checkOutput("rstpri_sel_oh", sel_oh, 16'h0000);
`endif
    checkOutput("rstpri_out_comb_post", {15'd0, out}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mux_16x1.md
# mux_16x1

16-to-1 single-bit multiplexer with a combinational output and an optional registered copy for pipelined consumers. The combinational path is a structural tree of 2:1 mux cells. A clocked capture stage provides a registered output and the registered select. The block is a leaf datapath cell used wherever one lane of a 16-bit bus must be picked by a 4-bit index.

## Interface
Parameters: none.

Ports:
- clk  input  1  rising-edge clock for the capture stage
- rst  input  1  reset; synchronous and active-high, sampled on the rising edge of clk
- en  input  1  capture enable for the registered stage
- in  input  16  data lanes; lane i is in[i]
- sel  input  4  lane index, unsigned 0..15
- out  output  1  combinational selected bit, out = in[sel]
- out_q  output  1  registered selected bit
- sel_q  output  4  registered lane index
- sel_oh  output  16  registered one-hot decode of sel; present only with MUX_16X1_ONEHOT_EN

## Operation
Combinational path:
- out = in[sel] for all 16 values of sel.
- The path is built as a 4-level tree of 15 two-input mux cells:
  - level 0: 8 cells steered by sel[0]
  - level 1: 4 cells steered by sel[1]
  - level 2: 2 cells steered by sel[2]
  - level 3: 1 cell steered by sel[3]
- Each cell computes y = (a & ~s) | (b & s), with a the even-index input and b the odd-index input.
- out does not depend on clk, rst or en.
- out is fully correct when clk, rst and en are left unconnected (Z/X). A bench may omit them entirely.
- No explicit delays in the RTL; out settles in zero simulation time.
- If sel has X/Z bits, out may be X. This is not checked.

Capture stage, on each rising clk edge:
- rst=1: out_q←0, sel_q←0, sel_oh←16'h0000.
- rst=0, en=1: out_q←in[sel], sel_q←sel, sel_oh←(16'h0001 << sel).
- rst=0, en=0: all registers hold their values.
- rst has priority over en.

## Timing
- out: 0-cycle latency, combinational from in and sel.
- out_q, sel_q, sel_oh: 1-cycle latency. They show the values sampled at the most recent enabled, non-reset edge.
- After a reset edge, registered outputs read 0 until the first enabled edge with rst=0.
- rst asserted mid-stream clears the registers at that edge; out keeps tracking its inputs.
- in or sel changing between edges affects only out, not the registers.
- When sel and in change simultaneously, out reflects the new pair once settled.

## Configuration
- MUX_16X1_ONEHOT_EN defined: the sel_oh port and its 16 registers exist.
  - Invariant: sel_oh has exactly one bit set, at position sel_q, after any enabled edge.
  - sel_oh is 0 after reset.
- MUX_16X1_ONEHOT_EN undefined: no sel_oh port and no sel_oh logic. All other behaviour is identical.

## Test plan
- Combinational only, clk/rst/en unconnected:
  - in=16'h5555, sweep sel 0..15 with 1 ns settle per step.
  - Required: out = 1 for even sel, 0 for odd sel, 16/16 matching.
- in=16'hAAAA, sweep sel 0..15 -> out = 0 for even sel, 1 for odd sel.
- in=16'h0001, sweep sel 0..15 -> out=1 only at sel=0, else 0.
- in=16'h8000, sweep sel 0..15 -> out=1 only at sel=15, else 0.
- Registered path:
  - Hold rst=1 for 2 edges -> out_q=0, sel_q=0.
  - Then rst=0, en=1, in=16'h8000, sel=15 -> after 1 edge out_q=1, sel_q=15, sel_oh=16'h8000 (if enabled).
  - Then en=0 and sel=0 -> out_q and sel_q hold while out=0.
- rst=1 and en=1 on the same edge with in=16'hFFFF -> out_q=0, sel_q=0; out stays 1 combinationally.
